// File: rtl/vxe_txnreq_if.sv
// Client request and packed request-vector signals for the VxE request encoder.
// The slave modport is the encoder's view; the master modport is its user's view.
interface vxe_txnreq_if #(
    parameter int unsigned DEPTH_POW2 = 2
);
    logic                  i_valid;
    logic                  o_ready;
    logic [5:0]            i_txnid;
    logic                  i_rnw;
    logic [36:0]           i_addr;
    logic [63:0]           i_data;
    logic [7:0]            i_ben;
    logic                  o_req_vec_valid;
    logic                  i_req_vec_ready;
    logic [43:0]           o_req_vec_txn;
    logic [71:0]           o_req_vec_dat;
    logic [DEPTH_POW2:0]   o_count;
    logic                  o_busy;

    modport slave (
        input  i_valid, i_txnid, i_rnw, i_addr, i_data, i_ben, i_req_vec_ready,
        output o_ready, o_req_vec_valid, o_req_vec_txn, o_req_vec_dat, o_count, o_busy
    );

    modport master (
        output i_valid, i_txnid, i_rnw, i_addr, i_data, i_ben, i_req_vec_ready,
        input  o_ready, o_req_vec_valid, o_req_vec_txn, o_req_vec_dat, o_count, o_busy
    );
endinterface

// File: rtl/vxe_txnreq_encoder.sv
// Packs client memory requests into VxE txn/data vectors and queues them in a
// small FIFO that decouples client backpressure from fabric backpressure.
module vxe_txnreq_encoder #(
    parameter int unsigned DEPTH_POW2 = 2
) (
    input  logic         clk,
    input  logic         rst,
    vxe_txnreq_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_POW2;
    localparam int unsigned PW    = DEPTH_POW2;
    localparam int unsigned CW    = DEPTH_POW2 + 1;
    localparam int unsigned TXN_W = 44;
    localparam int unsigned DAT_W = 72;

    typedef struct packed {
        logic [TXN_W-1:0] txn;
        logic [DAT_W-1:0] dat;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_nonempty;
    entry_t          w_entry;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty && bus.i_req_vec_ready;
    assign w_push     = bus.i_valid && bus.o_ready;

    // Reads carry no payload: data and byte enables are zeroed regardless of inputs.
    assign w_entry.txn = {bus.i_txnid, bus.i_rnw, bus.i_addr};
    assign w_entry.dat = bus.i_rnw ? DAT_W'(0) : {bus.i_ben, bus.i_data};

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign bus.o_ready         = !w_full || w_pop;
    assign bus.o_req_vec_valid = w_nonempty;
    assign bus.o_busy          = w_nonempty;
    assign bus.o_count         = r_count;
    assign bus.o_req_vec_txn   = r_mem[r_rd_ptr].txn;
    assign bus.o_req_vec_dat   = r_mem[r_rd_ptr].dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is intentionally not reset; the head is don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    a_count_max: assert property (@(posedge clk) disable iff (rst) r_count <= CW'(DEPTH));
    a_no_empty_pop: assert property (@(posedge clk) disable iff (rst) !(w_pop && r_count == '0));
endmodule

// File: tb/tb_vxe_txnreq_encoder.sv
// Scoreboard bench for vxe_txnreq_encoder: the driver queues expected vectors on
// accepted pushes, a monitor pops and compares on every downstream handshake.
module tb_vxe_txnreq_encoder;
    localparam int unsigned DP    = 2;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [43:0] txn;
        logic [71:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic man_rdy = 1'b0;
    logic rnd_rdy = 1'b0;
    bit   rnd_mode = 1'b0;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vxe_txnreq_if #(.DEPTH_POW2(DP)) bus ();

    vxe_txnreq_encoder #(.DEPTH_POW2(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.i_req_vec_ready = rnd_mode ? rnd_rdy : man_rdy;

    always @(posedge clk) begin
        #1;
        rnd_rdy = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor: a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
        end else if (bus.o_req_vec_valid === 1'b1 && bus.i_req_vec_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=%h required=none", bus.o_req_vec_txn);
            end else begin
                e = exp_q.pop_front();
                chk("pop_txn", 72'(bus.o_req_vec_txn), 72'(e.txn));
                chk("pop_dat", bus.o_req_vec_dat, e.dat);
            end
        end
    end

    // Occupancy seen by the DUT must match the number of outstanding expectations.
    always @(posedge clk) begin
        #2;
        chk("occ_count", 72'(bus.o_count), 72'(exp_q.size()));
        chk("occ_busy", 72'(bus.o_busy), 72'(exp_q.size() != 0));
        chk("occ_valid", 72'(bus.o_req_vec_valid), 72'(exp_q.size() != 0));
        if (bus.o_count > 3'(DEPTH)) begin
            checks++;
            errors++;
            $display("FAIL occ_max actual=%0d required<=%0d", bus.o_count, DEPTH);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [43:0] ptxn(input logic [5:0] id, input logic rnw, input logic [36:0] addr);
        return {id, rnw, addr};
    endfunction

    function automatic logic [71:0] pdat(input logic rnw, input logic [63:0] data, input logic [7:0] ben);
        return rnw ? 72'h0 : {ben, data};
    endfunction

    // Called at posedge+1; holds i_valid until accepted or maxwait extra cycles pass.
    task automatic send(input logic [5:0] id, input logic rnw, input logic [36:0] addr,
                        input logic [63:0] data, input logic [7:0] ben,
                        input logic [43:0] et, input logic [71:0] ed,
                        input int maxwait, output bit acc);
        bus.i_valid = 1'b1;
        bus.i_txnid = id;
        bus.i_rnw   = rnw;
        bus.i_addr  = addr;
        bus.i_data  = data;
        bus.i_ben   = ben;
        acc = 1'b0;
        for (int w = 0; w <= maxwait && !acc; w++) begin
            @(negedge clk);
            if (!rst && bus.o_ready === 1'b1) begin
                acc = 1'b1;
                exp_q.push_back('{et, ed});
            end
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic req(input logic [5:0] id, input logic rnw, input logic [36:0] addr,
                       input logic [63:0] data, input logic [7:0] ben, input int maxwait);
        bit acc;
        send(id, rnw, addr, data, ben, ptxn(id, rnw, addr), pdat(rnw, data, ben), maxwait, acc);
        chk("accept", 72'(acc), 72'(1));
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("drain", 72'(exp_q.size()), 72'(0));
    endtask

    initial begin
        bit acc;
        logic [43:0] t;
        bus.i_valid = 1'b0;
        bus.i_txnid = '0;
        bus.i_rnw   = 1'b0;
        bus.i_addr  = '0;
        bus.i_data  = '0;
        bus.i_ben   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 72'(bus.o_req_vec_valid), 72'(0));
        chk("rst_count", 72'(bus.o_count), 72'(0));
        chk("rst_busy", 72'(bus.o_busy), 72'(0));
        chk("rst_ready", 72'(bus.o_ready), 72'(1));
        @(posedge clk);
        #1;

        // 1: single write, one-cycle latency, hand-packed vectors
        man_rdy = 1'b1;
        send(6'h2A, 1'b0, 37'h1_2345_6789, 64'hDEADBEEF_CAFEF00D, 8'hF0,
             44'hA81_2345_6789, 72'hF0_DEADBEEF_CAFEF00D, 0, acc);
        chk("t1_accept", 72'(acc), 72'(1));
        chk("t1_valid", 72'(bus.o_req_vec_valid), 72'(1));
        chk("t1_txn", 72'(bus.o_req_vec_txn), 72'(44'hA81_2345_6789));
        chk("t1_dat", bus.o_req_vec_dat, 72'hF0_DEADBEEF_CAFEF00D);
        wait_drain(10);

        // 2: read with garbage payload is zeroed
        send(6'h15, 1'b1, 37'h0_0000_1000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF,
             44'h560_0000_1000, 72'h0, 0, acc);
        chk("t2_accept", 72'(acc), 72'(1));
        chk("t2_dat", bus.o_req_vec_dat, 72'h0);
        t = bus.o_req_vec_txn;
        chk("t2_rnw_bit", 72'(t[37]), 72'(1));
        wait_drain(10);

        // 3: fill with ready low, extra pushes refused, head stable
        man_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(6'(i), 1'b0, 37'(64'h100 + 64'(i)), 64'h1111_0000_0000_0000 + 64'(i), 8'(i), 0);
        end
        send(6'd4, 1'b0, 37'h104, 64'h4, 8'h04, 44'h0, 72'h0, 1, acc);
        chk("t3_reject4", 72'(acc), 72'(0));
        send(6'd5, 1'b0, 37'h105, 64'h5, 8'h05, 44'h0, 72'h0, 1, acc);
        chk("t3_reject5", 72'(acc), 72'(0));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            t = bus.o_req_vec_txn;
            chk("t3_valid_hold", 72'(bus.o_req_vec_valid), 72'(1));
            chk("t3_head_id", 72'(t[43:38]), 72'(0));
            chk("t3_ready_low", 72'(bus.o_ready), 72'(0));
            chk("t3_count_full", 72'(bus.o_count), 72'(4));
        end
        @(posedge clk);
        #1;

        // 4: full FIFO accepts a push alongside a pop
        man_rdy = 1'b1;
        send(6'd7, 1'b0, 37'h107, 64'h7777, 8'h77, ptxn(6'd7, 1'b0, 37'h107),
             pdat(1'b0, 64'h7777, 8'h77), 0, acc);
        chk("t4_passthru_accept", 72'(acc), 72'(1));
        chk("t4_count_held", 72'(bus.o_count), 72'(4));
        wait_drain(20);

        // 5: wrap-around stream under random backpressure
        rnd_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req(6'(i), 1'(i % 2), 37'(64'h2000 + 64'(i * 3)), {32'hA5A5_0000, 32'(i)}, 8'(8'h11 * (i % 8)), 50);
        end
        rnd_mode = 1'b0;
        man_rdy  = 1'b1;
        wait_drain(100);

        // 6: reset mid-operation discards contents and the concurrent push
        man_rdy = 1'b0;
        req(6'd20, 1'b0, 37'h300, 64'h20, 8'hFF, 0);
        req(6'd21, 1'b1, 37'h301, 64'h21, 8'hFF, 0);
        req(6'd22, 1'b0, 37'h302, 64'h22, 8'h0F, 0);
        chk("t6_count3", 72'(bus.o_count), 72'(3));
        rst = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_txnid = 6'd50;
        bus.i_rnw   = 1'b0;
        bus.i_addr  = 37'h350;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_valid = 1'b0;
        chk("t6_count0", 72'(bus.o_count), 72'(0));
        chk("t6_valid0", 72'(bus.o_req_vec_valid), 72'(0));
        @(negedge clk);
        chk("t6_ready", 72'(bus.o_ready), 72'(1));
        @(posedge clk);
        #1;
        man_rdy = 1'b1;
        req(6'd9, 1'b0, 37'h309, 64'h9999, 8'hAA, 0);
        t = bus.o_req_vec_txn;
        chk("t6_first_id", 72'(t[43:38]), 72'(9));
        wait_drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vxe_txnreq_encoder.md
Name: vxe_txnreq_encoder

Overview:
Request-side transaction encoder. It accepts memory request fields (txnid, rnw, address, data, byte enables) from a client over a valid/ready handshake. It packs them into the 44-bit transaction vector and 72-bit data vector used on the VxE request channel, and buffers them in a small FIFO. It drives the packed vectors toward the interconnect with its own valid/ready handshake, decoupling client and fabric backpressure.

Parameters:
DEPTH_POW2, 2, log2 of FIFO depth; depth = 2**DEPTH_POW2 (legal range 1..4, so depth 2..16)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
i_valid  input  1  client request valid
o_ready  output  1  encoder can accept a request this cycle
i_txnid  input  6  transaction id
i_rnw  input  1  1 = read, 0 = write
i_addr  input  37  upper 37 bits of 40-bit byte address (8-byte aligned)
i_data  input  64  write data
i_ben  input  8  write byte enables
o_req_vec_valid  output  1  packed request valid
i_req_vec_ready  input  1  downstream accepts packed request
o_req_vec_txn  output  44  {txnid[5:0], rnw, addr[36:0]}: txnid at [43:38], rnw at [37], addr at [36:0]
o_req_vec_dat  output  72  {ben[7:0], data[63:0]}: ben at [71:64], data at [63:0]
o_count  output  DEPTH_POW2+1  current FIFO occupancy
o_busy  output  1  FIFO non-empty

Behaviour:
- Reset: sync, active-high, dominates all other inputs in the same cycle. Clears read ptr, write ptr and count.
- Outputs in and after reset: o_req_vec_valid=0, o_count=0, o_busy=0, o_ready=1 from the first cycle after rst deasserts. FIFO storage is not reset; o_req_vec_txn/dat are don't-care while valid=0.
- Push: occurs when i_valid && o_ready. Push data is packed combinationally and written at the clock edge.
- o_ready = (count != DEPTH) || pop. A full FIFO accepts a push in the same cycle a pop occurs (pass-through when full).
- Read packing: when i_rnw=1, the stored data field is forced to 64'h0 and ben to 8'h00, regardless of i_data/i_ben.
- Write packing: when i_rnw=0, i_data and i_ben are stored verbatim. ben=8'h00 on a write is legal and is passed unchanged.
- Pop: occurs when o_req_vec_valid && i_req_vec_ready.
- o_req_vec_valid = (count != 0). Outputs are driven from FIFO head storage (registered; no combinational path from i_* to o_req_vec_*).
- Latency: a push at edge N is visible on the outputs after edge N (one cycle minimum, empty FIFO). An empty FIFO does not bypass the push.
- Output stability: while o_req_vec_valid=1 && i_req_vec_ready=0, o_req_vec_txn/dat must stay stable, and valid must not drop.
- Pointers: wrap modulo DEPTH (natural binary wrap of DEPTH_POW2-bit pointers).
- Count update:
  - push-only: +1
  - pop-only: -1
  - push+pop: unchanged, with both pointers advancing
  - neither: hold
- Empty + push + downstream ready: no pop in that cycle, because valid=0. The entry pops on a following cycle.
- No overflow or underflow is possible by construction. Assertions (simulation only): count <= DEPTH; no pop when count==0.
- Order: strict FIFO. The encoder applies no txnid reordering or uniqueness checks; uniqueness is the client's responsibility.
- o_busy = (count != 0). It is used by the engine's idle detection.

Test Plan:
1. Reset then single write: txnid=6'h2A, rnw=0, addr=37'h1_2345_6789, data=64'hDEADBEEF_CAFEF00D, ben=8'hF0, with i_req_vec_ready=1 -> valid rises one cycle later; txn=44'hA81_2345_6789 (txnid 6'h2A at [43:38], rnw 0 at [37], addr 37'h1_2345_6789 at [36:0]); dat=72'hF0_DEADBEEF_CAFEF00D; popped next edge; count returns to 0.
2. Read with garbage data: rnw=1, data=64'hFFFF_FFFF_FFFF_FFFF, ben=8'hFF -> dat=72'h0; txn bit 37=1.
3. Fill with DEPTH_POW2=2, ready held 0: push txnid 0..5 back-to-back -> ids 0..3 accepted; o_ready=0 with count=4; valid held with txn[43:38]=0 stable for 10 cycles.
4. Full-FIFO simultaneous push/pop: at count=4, raise ready with i_valid=1 (id 7) -> o_ready=1, count stays 4. Drain order is 1,2,3,7.
5. Wrap-around: stream 20 requests (ids 0..19 mod 64) with random ready (~50%) -> every id output exactly once in order; o_count never exceeds 4.
6. Reset mid-operation: count=3, assert rst for one cycle with i_valid=1 -> count=0, valid=0, push ignored; next push of id 9 appears first.
